// File: rtl/byte_striping_if.sv
// byte_striping_if: word stream in, two striped lanes out.
interface byte_striping_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] lane_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_0;
    logic              valid_1;
    logic              lane_sel;
    logic [7:0]        word_cnt;
    modport master (output data_in, valid_in, input lane_0, lane_1, valid_0, valid_1, lane_sel, word_cnt);
    modport slave  (input data_in, valid_in, output lane_0, lane_1, valid_0, valid_1, lane_sel, word_cnt);
endinterface

// File: rtl/byte_striping.sv
// byte_striping: round-robin split of one word stream onto two lanes, with idle-gap resync to lane 0.
// Define STRIPING_PAD_EN to emit PAD_WORD on lane_1 when a resync leaves lane 1 short.
module byte_striping #(
    parameter int          DATA_W      = 32,
    parameter int          IDLE_RESYNC = 4,
    parameter [DATA_W-1:0] PAD_WORD    = 32'h0000_00BC
) (
    input logic            clk_2f,
    input logic            reset,
    byte_striping_if.slave bus
);
`ifdef STRIPING_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int CW = IDLE_RESYNC > 1 ? $clog2(IDLE_RESYNC + 1) : 1;
    logic [DATA_W-1:0] r_lane_0, r_lane_1;
    logic              r_valid_0, r_valid_1, r_sel;
    logic [7:0]        r_cnt;
    logic [CW-1:0]     r_idle;
    logic              w_resync;
    generate
        if (IDLE_RESYNC == 0) begin : g_no_resync
            assign w_resync = 1'b0;
            always_ff @(posedge clk_2f) r_idle <= '0;
        end else begin : g_resync
            // counter saturates so the event fires once per idle gap
            assign w_resync = !bus.valid_in && r_idle == CW'(IDLE_RESYNC - 1);
            always_ff @(posedge clk_2f) begin
                if (reset || bus.valid_in)
                    r_idle <= '0;
                else if (r_idle != CW'(IDLE_RESYNC))
                    r_idle <= r_idle + CW'(1);
            end
        end
    endgenerate
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_lane_0  <= '0;
            r_lane_1  <= '0;
            r_valid_0 <= 1'b0;
            r_valid_1 <= 1'b0;
            r_sel     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_valid_0 <= bus.valid_in && !r_sel;
            r_valid_1 <= bus.valid_in && r_sel;
            if (bus.valid_in) begin
                if (r_sel)
                    r_lane_1 <= bus.data_in;
                else
                    r_lane_0 <= bus.data_in;
                r_sel <= ~r_sel;
                r_cnt <= r_cnt + 8'd1;
            end else if (w_resync && r_sel) begin
                r_sel <= 1'b0;
                if (PAD_EN) begin
                    r_lane_1  <= PAD_WORD;
                    r_valid_1 <= 1'b1;
                end
            end
        end
    end
    assign bus.lane_0   = r_lane_0;
    assign bus.lane_1   = r_lane_1;
    assign bus.valid_0  = r_valid_0;
    assign bus.valid_1  = r_valid_1;
    assign bus.lane_sel = r_sel;
    assign bus.word_cnt = r_cnt;
endmodule

// File: tb/tb_byte_striping.sv
// tb_byte_striping: vector table, hand-written resync/wrap sequences and random traffic against a word-count model.
module tb_byte_striping;
`ifdef STRIPING_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int RES = 4;
    logic clk_2f = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    byte_striping_if #(.DATA_W(32)) bus ();
    byte_striping dut (.clk_2f(clk_2f), .reset(reset), .bus(bus));
    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        e_v0;
        logic        e_v1;
        logic [31:0] e_l0;
        logic [31:0] e_l1;
        logic        e_sel;
        logic [7:0]  e_cnt;
    } vec_t;
    vec_t vecs[15];

    // behavioural model: lane chosen by parity of words since last reset/resync
    logic [31:0] m_l0, m_l1;
    logic        m_v0, m_v1;
    int          m_seg, m_idle, m_total;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d);
        reset = r;
        bus.valid_in = v;
        bus.data_in = d;
        @(posedge clk_2f);
        #1;
        if (r) begin
            m_l0 = 0; m_l1 = 0; m_v0 = 0; m_v1 = 0;
            m_seg = 0; m_idle = 0; m_total = 0;
        end else if (v) begin
            m_v0 = (m_seg % 2) == 0;
            m_v1 = !m_v0;
            if (m_v0) m_l0 = d; else m_l1 = d;
            m_seg++; m_total++; m_idle = 0;
        end else begin
            m_v0 = 0; m_v1 = 0;
            m_idle++;
            if (m_idle == RES && (m_seg % 2) == 1) begin
                m_seg = 0;
                if (PAD) begin m_l1 = 32'hBC; m_v1 = 1; end
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".v0"}, 32'(bus.valid_0), 32'(m_v0));
        chk({tag, ".v1"}, 32'(bus.valid_1), 32'(m_v1));
        chk({tag, ".l0"}, bus.lane_0, m_l0);
        chk({tag, ".l1"}, bus.lane_1, m_l1);
        chk({tag, ".sel"}, 32'(bus.lane_sel), 32'(m_seg % 2));
        chk({tag, ".cnt"}, 32'(bus.word_cnt), 32'(m_total % 256));
    endtask

    initial begin
        bit both;
        vecs[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 8'd0};
        vecs[1]  = '{1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 8'd0};
        vecs[2]  = '{0, 1, 32'h11111111, 1, 0, 32'h11111111, 32'h0,        1, 8'd1};
        vecs[3]  = '{0, 1, 32'h22222222, 0, 1, 32'h11111111, 32'h22222222, 0, 8'd2};
        vecs[4]  = '{0, 1, 32'h33333333, 1, 0, 32'h33333333, 32'h22222222, 1, 8'd3};
        vecs[5]  = '{0, 1, 32'h44444444, 0, 1, 32'h33333333, 32'h44444444, 0, 8'd4};
        vecs[6]  = '{0, 1, 32'h55555555, 1, 0, 32'h55555555, 32'h44444444, 1, 8'd5};
        vecs[7]  = '{0, 0, 32'hFFFFFFFF, 0, 0, 32'h55555555, 32'h44444444, 1, 8'd5};
        vecs[8]  = '{0, 0, 32'h00000000, 0, 0, 32'h55555555, 32'h44444444, 1, 8'd5};
        vecs[9]  = '{0, 1, 32'h66666666, 0, 1, 32'h55555555, 32'h66666666, 0, 8'd6};
        vecs[10] = '{0, 1, 32'h77777777, 1, 0, 32'h77777777, 32'h66666666, 1, 8'd7};
        vecs[11] = '{0, 1, 32'h88888888, 0, 1, 32'h77777777, 32'h88888888, 0, 8'd8};
        vecs[12] = '{0, 1, 32'h99999999, 1, 0, 32'h99999999, 32'h88888888, 1, 8'd9};
        vecs[13] = '{1, 1, 32'hAAAAAAAA, 0, 0, 32'h0,        32'h0,        0, 8'd0};
        vecs[14] = '{0, 1, 32'hBBBBBBBB, 1, 0, 32'hBBBBBBBB, 32'h0,        1, 8'd1};
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d.v0", i), 32'(bus.valid_0), 32'(vecs[i].e_v0));
            chk($sformatf("vec%0d.v1", i), 32'(bus.valid_1), 32'(vecs[i].e_v1));
            chk($sformatf("vec%0d.l0", i), bus.lane_0, vecs[i].e_l0);
            chk($sformatf("vec%0d.l1", i), bus.lane_1, vecs[i].e_l1);
            chk($sformatf("vec%0d.sel", i), 32'(bus.lane_sel), 32'(vecs[i].e_sel));
            chk($sformatf("vec%0d.cnt", i), 32'(bus.word_cnt), 32'(vecs[i].e_cnt));
        end
        // odd word count (1) then 4 idle cycles: resync on the 4th
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 32'hDEADBEEF);
            chk($sformatf("gap%0d.sel", i), 32'(bus.lane_sel), 32'd1);
            chk($sformatf("gap%0d.v1", i), 32'(bus.valid_1), 32'd0);
        end
        step(0, 0, 32'hDEADBEEF);
        chk("resync.sel", 32'(bus.lane_sel), 32'd0);
        chk("resync.v0", 32'(bus.valid_0), 32'd0);
        chk("resync.v1", 32'(bus.valid_1), PAD ? 32'd1 : 32'd0);
        chk("resync.l1", bus.lane_1, PAD ? 32'hBC : 32'h0);
        chk("resync.cnt", 32'(bus.word_cnt), 32'd1);
        step(0, 0, 32'h0);
        chk("post_resync.v1", 32'(bus.valid_1), 32'd0);
        step(0, 1, 32'hCAFE0001);
        chk("after_resync.v0", 32'(bus.valid_0), 32'd1);
        chk("after_resync.l0", bus.lane_0, 32'hCAFE0001);
        // even count (2) then 6 idle cycles: no pad, pointer stays 0
        step(0, 1, 32'hCAFE0002);
        both = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h12345678);
            both |= bus.valid_0 | bus.valid_1 | bus.lane_sel;
        end
        chk("even_gap.quiet", 32'(both), 32'd0);
        chk("even_gap.l1", bus.lane_1, 32'hCAFE0002);
        step(0, 1, 32'hCAFE0003);
        chk("even_next.v0", 32'(bus.valid_0), 32'd1);
        chk("even_next.l0", bus.lane_0, 32'hCAFE0003);
        // 257 back-to-back words: counter wraps
        step(1, 0, 32'h0);
        both = 0;
        for (int i = 0; i < 257; i++) begin
            step(0, 1, 32'(i));
            both |= bus.valid_0 & bus.valid_1;
        end
        chk("wrap.cnt", 32'(bus.word_cnt), 32'd1);
        chk("wrap.sel", 32'(bus.lane_sel), 32'd1);
        chk("wrap.both", 32'(both), 32'd0);
        chk("wrap.l0", bus.lane_0, 32'd256);
        // randomized bursts and gaps against the model
        step(1, 0, 32'h0);
        cmp_model("rst");
        for (int n = 0; n < 400; n++) begin
            int len;
            bit v;
            v = $urandom_range(0, 1) == 1;
            len = v ? $urandom_range(1, 5) : $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                step($urandom_range(0, 99) == 0, v, $urandom);
                cmp_model($sformatf("rnd%0d", n));
                chk($sformatf("rnd%0d.excl", n), 32'(bus.valid_0 & bus.valid_1), 32'd0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
